// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types and helpers for the UART command decoder.
//   state_t      : frame sequencing states of the decoder FSM
//   err_code_t   : error codes reported on o_err_code
//   SYNC_BYTE_DEFAULT : default frame start marker
//   timeout_clks : inter-byte timeout length in clocks
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_OVERRUN = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // One byte time on the wire is 10 bit periods (start + 8 data + stop).
  function automatic int unsigned timeout_clks(input int unsigned clks_per_bit,
                                               input int unsigned timeout_bytes);
    return timeout_bytes * 10 * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// -----------------------------------------------------------------------------
// uart_cmd_buf
// Payload storage: DEPTH x 8 register array, synchronous write, asynchronous
// read. Cleared by reset.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en_i     : write strobe
//   wr_idx_i    : write index
//   wr_data_i   : write data
//   rd_idx_i    : read index
//   rd_data_o   : combinational read data (0 for indices beyond DEPTH)
// -----------------------------------------------------------------------------
module uart_cmd_buf #(
  parameter int DEPTH = 16,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [7:0]    wr_data_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (int'(rd_idx_i) < DEPTH) begin
      rd_data_o = mem_q[rd_idx_i];
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
// Frame-level controller behind a UART receiver. Hunts for SYNC_BYTE, then
// sequences CMD, LEN, LEN payload bytes and an XOR checksum. A validated frame
// is presented on o_cmd/o_len with the payload readable through i_rd_idx.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_RX_DV       : one-cycle byte strobe from the receiver
//   i_RX_Byte     : received byte, qualified by i_RX_DV
//   o_cmd_valid   : validated command available (held until acked)
//   i_cmd_ack     : consumer accepts the command
//   o_cmd, o_len  : command byte and payload length of the held command
//   i_rd_idx      : payload read index
//   o_rd_data     : payload byte at i_rd_idx (combinational)
//   o_err         : one-cycle error pulse
//   o_err_code    : code of the most recent error (err_code_t)
//   o_dbg_state   : current FSM state, for observation only
//
// Handshake: o_cmd_valid rises the cycle after a matching checksum byte and
// stays high, with o_cmd/o_len/payload frozen, until a cycle in which
// i_cmd_ack is high; o_cmd_valid is low on the following cycle. i_cmd_ack is
// ignored while o_cmd_valid is low.
// -----------------------------------------------------------------------------
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter  int         CLKS_PER_BIT  = 434,
  parameter  int         MAX_LEN       = 16,
  parameter  int         TIMEOUT_BYTES = 4,
  parameter  logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  localparam int         LW            = $clog2(MAX_LEN + 1),
  localparam int         IW            = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte,
  output logic          o_cmd_valid,
  input  logic          i_cmd_ack,
  output logic [7:0]    o_cmd,
  output logic [LW-1:0] o_len,
  input  logic [IW-1:0] i_rd_idx,
  output logic [7:0]    o_rd_data,
  output logic          o_err,
  output logic [1:0]    o_err_code,
  output state_t        o_dbg_state
);

  localparam int unsigned TMO_CLKS = timeout_clks(CLKS_PER_BIT, TIMEOUT_BYTES);
  localparam int unsigned TMO_LAST = TMO_CLKS - 1;
  localparam int          TW       = $clog2(TMO_CLKS);

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;          // command of the frame in progress
  logic [LW-1:0] len_q, len_d;          // length of the frame in progress
  logic [IW-1:0] idx_q, idx_d;          // payload write index
  logic [7:0]    csum_q, csum_d;        // running XOR
  logic [7:0]    out_cmd_q, out_cmd_d;
  logic [LW-1:0] out_len_q, out_len_d;
  logic          err_q, err_d;
  err_code_t     err_code_q, err_code_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          wr_en;
  logic          in_frame;

  // Timeout only matters once a sync byte has been seen and before the
  // command is handed off.
  assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                    (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      out_cmd_q  <= '0;
      out_len_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_OVERRUN;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      out_cmd_q  <= out_cmd_d;
      out_len_q  <= out_len_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    out_cmd_d  = out_cmd_q;
    out_len_d  = out_len_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    tmo_d      = '0;
    wr_en      = 1'b0;

    if (in_frame && !i_RX_DV) begin
      tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        if (i_RX_DV) begin
          cmd_d   = i_RX_Byte;
          csum_d  = i_RX_Byte;
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (i_RX_DV) begin
          if (int'(i_RX_Byte) > MAX_LEN) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d   = i_RX_Byte[LW-1:0];
            csum_d  = csum_q ^ i_RX_Byte;
            idx_d   = '0;
            state_d = (i_RX_Byte == 8'd0) ? ST_CSUM : ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (i_RX_DV) begin
          wr_en  = 1'b1;
          csum_d = csum_q ^ i_RX_Byte;
          idx_d  = idx_q + IW'(1);
          if ((LW'(idx_q) + LW'(1)) == len_q) begin
            state_d = ST_CSUM;
          end
        end
      end

      ST_CSUM: begin
        if (i_RX_DV) begin
          if (i_RX_Byte == csum_q) begin
            out_cmd_d = cmd_q;
            out_len_d = len_q;
            state_d   = ST_HOLD;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
            state_d    = ST_IDLE;
          end
        end
      end

      ST_HOLD: begin
        // Bytes arriving while a command is pending are lost; this includes
        // the ack cycle, so such a byte can never start a new frame.
        if (i_RX_DV) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (i_cmd_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A strobe in the expiry cycle takes precedence over the timeout.
    if (in_frame && !i_RX_DV && (tmo_q == TW'(TMO_LAST))) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_IDLE;
      tmo_d      = '0;
    end
  end

  uart_cmd_buf #(
    .DEPTH (MAX_LEN),
    .IW    (IW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx_q),
    .wr_data_i (i_RX_Byte),
    .rd_idx_i  (i_rd_idx),
    .rd_data_o (o_rd_data)
  );

  assign o_cmd_valid = (state_q == ST_HOLD);
  assign o_cmd       = out_cmd_q;
  assign o_len       = out_len_q;
  assign o_err       = err_q;
  assign o_err_code  = err_code_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
`timescale 1ns/1ps
module tb_uart_cmd_decoder;
  import uart_cmd_pkg::*;

  localparam int          MAX_LEN  = 16;
  localparam int          LW       = 5;
  localparam int          IW       = 4;
  localparam int unsigned TMO_CLKS = 17360;  // 4 bytes * 10 bits * 434 clocks
  localparam logic [7:0]  SYNC     = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          cmd_ack = 1'b0;
  logic [IW-1:0] rd_idx = '0;
  logic          cmd_valid;
  logic [7:0]    cmd;
  logic [LW-1:0] len;
  logic [7:0]    rd_data;
  logic          err;
  logic [1:0]    err_code;
  state_t        dbg_state;

  uart_cmd_decoder #(
    .CLKS_PER_BIT  (434),
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_BYTES (4),
    .SYNC_BYTE     (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .o_cmd_valid (cmd_valid),
    .i_cmd_ack   (cmd_ack),
    .o_cmd       (cmd),
    .o_len       (len),
    .i_rd_idx    (rd_idx),
    .o_rd_data   (rd_data),
    .o_err       (err),
    .o_err_code  (err_code),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Event word: bit 15 = command event; [12:8] len, [7:0] cmd; else [1:0] err code.
  logic [15:0] exp_q[$];
  int unsigned exp_edge_q[$];
  int checks = 0;
  int fails  = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void flag(input string name);
    checks++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  // ---------------- reference model ----------------
  // Works on the collected frame bytes: fr[0]=sync, fr[1]=cmd, fr[2]=len, ...
  logic [7:0]  fr[$];
  bit          mdl_hold = 1'b0;
  logic [7:0]  mdl_buf [MAX_LEN];
  int unsigned last_edge = 0;

  function automatic void push_err(input logic [1:0] code);
    exp_q.push_back({14'd0, code});
    exp_edge_q.push_back(edge_cnt);
  endfunction

  function automatic void push_cmd(input logic [7:0] c, input logic [7:0] l);
    exp_q.push_back({1'b1, 2'b00, l[4:0], c});
    exp_edge_q.push_back(edge_cnt);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int n;
    logic [7:0] x;
    if (mdl_hold) begin
      push_err(2'd0);
      return;
    end
    if (fr.size() == 0) begin
      if (b == SYNC) begin
        fr.push_back(b);
        last_edge = edge_cnt;
      end
      return;
    end
    fr.push_back(b);
    last_edge = edge_cnt;
    n = fr.size();
    if (n == 3 && int'(b) > MAX_LEN) begin
      push_err(2'd1);
      fr.delete();
    end else if (n >= 4 && n <= 3 + int'(fr[2])) begin
      mdl_buf[n-4] = b;
    end else if (n >= 4 && n == 4 + int'(fr[2])) begin
      x = 8'h00;
      for (int i = 1; i < n - 1; i++) x = x ^ fr[i];
      if (x == b) begin
        push_cmd(fr[1], fr[2]);
        mdl_hold = 1'b1;
      end else begin
        push_err(2'd2);
      end
      fr.delete();
    end
  endfunction

  // ---------------- driver tasks ----------------
  logic [7:0] tx_q[$];

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(posedge clk);
    #1;
    model_byte(b);
    rx_dv = 1'b0;
  endtask

  task automatic send_q();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (fr.size() != 0 && (edge_cnt - last_edge) == TMO_CLKS) begin
        push_err(2'd3);
        fr.delete();
      end
    end
  endtask

  task automatic do_ack();
    cmd_ack = 1'b1;
    @(posedge clk);
    #1;
    mdl_hold = 1'b0;
    cmd_ack  = 1'b0;
  endtask

  task automatic ack_with_byte(input logic [7:0] b);
    cmd_ack = 1'b1;
    rx_byte = b;
    rx_dv   = 1'b1;
    @(posedge clk);
    #1;
    model_byte(b);
    mdl_hold = 1'b0;
    cmd_ack  = 1'b0;
    rx_dv    = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    fr.delete();
    mdl_hold = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) mdl_buf[i] = 8'h00;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add_frame(input logic [7:0] c, input int l, input bit corrupt);
    logic [7:0] x;
    logic [7:0] p;
    x = c ^ 8'(l);
    tx_q.push_back(SYNC);
    tx_q.push_back(c);
    tx_q.push_back(8'(l));
    for (int i = 0; i < l; i++) begin
      p = 8'($urandom);
      tx_q.push_back(p);
      x = x ^ p;
    end
    tx_q.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  task automatic ack_if_held(input int max_wait);
    if (mdl_hold) begin
      idle($urandom_range(0, max_wait));
      do_ack();
    end
  endtask

  // ---------------- monitor ----------------
  logic [1:0]  mon_last_code = 2'd0;
  logic        prev_valid = 1'b0;
  logic [7:0]  held_cmd = '0;
  logic [4:0]  held_len = '0;

  initial begin
    logic [15:0] e;
    int unsigned ed;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cmd", 32'(cmd), 0);
        check("rst_len", 32'(len), 0);
        check("rst_err_code", 32'(err_code), 0);
        mon_last_code = 2'd0;
        prev_valid    = 1'b0;
      end else begin
        check("valid_level", 32'(cmd_valid), 32'(mdl_hold));
        if (err) begin
          if (exp_q.size() == 0) begin
            flag("unexpected_err_pulse");
          end else begin
            e  = exp_q.pop_front();
            ed = exp_edge_q.pop_front();
            check("event_kind_err", 32'(e[15]), 0);
            check("err_code", 32'(err_code), 32'(e[1:0]));
            check("err_cycle", ed, edge_cnt);
            mon_last_code = e[1:0];
          end
        end else begin
          check("err_code_hold", 32'(err_code), 32'(mon_last_code));
        end
        if (cmd_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            flag("unexpected_cmd_valid");
          end else begin
            e  = exp_q.pop_front();
            ed = exp_edge_q.pop_front();
            check("event_kind_cmd", 32'(e[15]), 1);
            check("valid_cycle", ed, edge_cnt);
            held_cmd = e[7:0];
            held_len = e[12:8];
          end
        end
        if (cmd_valid) begin
          check("o_cmd", 32'(cmd), 32'(held_cmd));
          check("o_len", 32'(len), 32'(held_len));
          for (int i = 0; i < MAX_LEN; i++) begin
            rd_idx = IW'(i);
            #0.2;
            check("rd_data", 32'(rd_data), 32'(mdl_buf[i]));
          end
        end
        prev_valid = cmd_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    do_reset(3);
    idle(2);

    // Leading garbage, then a good frame; ack clears valid.
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'h34};
    send_q();
    idle(3);
    do_ack();
    idle(2);
    do_ack();  // ack while idle is ignored
    idle(2);

    // Bad checksum.
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'h35};
    send_q();
    idle(3);

    // Bad length, then a zero-length frame.
    tx_q = '{8'hA5, 8'h20, 8'h11};
    send_q();
    idle(2);
    tx_q = '{8'hA5, 8'h05, 8'h00, 8'h05};
    send_q();
    idle(2);
    do_ack();
    idle(2);

    // Strobe lands exactly in the expiry cycle: byte wins, frame completes.
    tx_q = '{8'hA5, 8'h10};
    send_q();
    idle(TMO_CLKS - 1);
    tx_q = '{8'h02, 8'h12, 8'h34, 8'h34};
    send_q();
    idle(2);
    do_ack();

    // Timeout after CMD, then a good frame.
    tx_q = '{8'hA5, 8'h10};
    send_q();
    idle(TMO_CLKS + 5);
    add_frame(8'h42, 5, 1'b0);
    send_q();
    idle(2);
    do_ack();
    idle(2);

    // Overrun while held, including on the ack cycle; the dropped A5 must not
    // start a frame, so the following 20 00 20 is ignored.
    add_frame(8'h33, 3, 1'b0);
    send_q();
    idle(2);
    send_byte(8'hA5);
    idle(3);
    ack_with_byte(8'hA5);
    tx_q = '{8'h20, 8'h00, 8'h20};
    send_q();
    idle(2);
    add_frame(8'h77, 16, 1'b0);
    send_q();
    idle(1);
    do_ack();
    idle(2);

    // Reset in the middle of a payload, then a good frame.
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h12};
    send_q();
    idle(1);
    do_reset(3);
    idle(2);
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'h34};
    send_q();
    idle(2);
    do_ack();
    idle(2);

    // Randomized traffic, back-to-back and with short gaps.
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        repeat ($urandom_range(1, 4)) tx_q.push_back(8'($urandom));
      end else if (kind == 1) begin
        add_frame(8'($urandom), 1, 1'b0);
        void'(tx_q.pop_back());
        void'(tx_q.pop_back());
        tx_q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
      end else if (kind == 2) begin
        add_frame(8'($urandom), $urandom_range(0, MAX_LEN), 1'b1);
      end else begin
        add_frame(8'($urandom), $urandom_range(0, MAX_LEN), 1'b0);
      end
      send_q();
      if (mdl_hold && $urandom_range(0, 3) == 0) begin
        idle($urandom_range(0, 2));
        send_byte(8'($urandom));
      end
      if (mdl_hold && $urandom_range(0, 4) == 0) begin
        ack_with_byte(8'($urandom));
      end else begin
        ack_if_held(4);
      end
      idle($urandom_range(0, 3));
    end

    // Drain outstanding expectations with a bounded wait.
    idle(5);
    for (int w = 0; w < 50 && exp_q.size() > 0; w++) idle(1);
    if (exp_q.size() != 0) flag("expected_events_not_seen");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
